// File: rtl/romb_stream_reader.sv
// Read sequencer in front of an SB_RAM40_4K used as a 256x16 ROM: issues
// LENGTH reads from BASE and presents the words as a valid/ready stream.
module romb_stream_reader #(
   parameter int AW    = 11,
   parameter int DW    = 16,
   parameter int DEPTH = 256,
   parameter int LW    = 9
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          START,
   input  logic [AW-1:0] BASE,
   input  logic [LW-1:0] LENGTH,
   output logic [AW-1:0] RADDR,
   output logic          RE,
   input  logic [DW-1:0] RDATA,
   output logic [DW-1:0] O_DATA,
   output logic          O_VALID,
   input  logic          O_READY,
   output logic          BUSY,
   output logic          DONE
);
   localparam int AB = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [AB-1:0] addr_q, addr_d;
   logic [LW-1:0] remain_q, remain_d;
   logic          inflight_q, inflight_d;
   logic [DW-1:0] mem_q [2];
   logic [DW-1:0] mem_d [2];
   logic          wptr_q, wptr_d, rptr_q, rptr_d;
   logic [1:0]    count_q, count_d;
   logic          zdone_q, zdone_d;

   logic [1:0]    occ;
   logic          issue, pop, pop_fifo, push, last_xfer;
   logic          unused_base;

   assign unused_base = ^BASE[AW-1:AB];

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      zdone_d    = 1'b0;

      // The word returning from the BRAM this cycle counts as an occupied slot
      // and is bypassed straight to the output when the FIFO is empty.
      occ        = count_q + {1'b0, inflight_q};
      issue      = (state_q == S_RUN) && (remain_q != '0) && (occ < 2'd2);
      O_VALID    = (count_q != 2'd0) || inflight_q;
      O_DATA     = (count_q == 2'd0 && inflight_q) ? RDATA : mem_q[rptr_q];
      pop        = O_VALID && O_READY;
      pop_fifo   = pop && (count_q != 2'd0);
      push       = inflight_q && !(pop && count_q == 2'd0);
      last_xfer  = (state_q == S_DRAIN) && pop && (occ == 2'd1);
      inflight_d = issue;

      if (push) begin
         mem_d[wptr_q] = RDATA;
         wptr_d        = ~wptr_q;
      end
      if (pop_fifo) rptr_d = ~rptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop_fifo};

      if (issue) begin
         addr_d   = addr_q + 1'b1;
         remain_d = remain_q - 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (START) begin
               addr_d   = BASE[AB-1:0];
               remain_d = LENGTH;
               if (LENGTH != '0) state_d = S_RUN;
               else              zdone_d = 1'b1;
            end
         end
         S_RUN:   if (issue && remain_q == LW'(1)) state_d = S_DRAIN;
         S_DRAIN: if (last_xfer) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         inflight_q <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         count_q    <= 2'd0;
         zdone_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         inflight_q <= inflight_d;
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         zdone_q    <= zdone_d;
      end
   end

   assign RADDR = {{(AW-AB){1'b0}}, addr_q};
   assign RE    = issue;
   assign BUSY  = (state_q != S_IDLE);
   assign DONE  = zdone_q | last_xfer;

endmodule

// File: tb/tb_romb_stream_reader.sv
// Bench for romb_stream_reader: BRAM-as-ROM model plus a stream monitor,
// compared against address/word sequences derived from BASE and LENGTH.
module tb_romb_stream_reader;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        START = 1'b0;
   logic [10:0] BASE = '0;
   logic [8:0]  LENGTH = '0;
   logic [10:0] RADDR;
   logic        RE;
   logic [15:0] RDATA = '0;
   logic [15:0] O_DATA;
   logic        O_VALID;
   logic        O_READY = 1'b0;
   logic        BUSY;
   logic        DONE;

   romb_stream_reader dut (
      .CLK(CLK), .RESET(RESET), .START(START), .BASE(BASE), .LENGTH(LENGTH),
      .RADDR(RADDR), .RE(RE), .RDATA(RDATA), .O_DATA(O_DATA), .O_VALID(O_VALID),
      .O_READY(O_READY), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ROM contents and 1-cycle-latency read port that holds when RE=0
   logic [15:0] rom [256];
   always @(posedge CLK) if (RE) RDATA <= rom[RADDR[7:0]];

   // Monitor observations
   logic [15:0] got_q[$];
   int          xcyc_q[$];
   int          ra_q[$];
   int          done_q[$];
   int          issued, xfers, stall_err, credit_err, first_v;
   bit          prev_stall;
   logic [15:0] prev_data;
   bit          busy_h [int];

   task automatic clear_mon();
      got_q.delete(); xcyc_q.delete(); ra_q.delete(); done_q.delete();
      issued = 0; xfers = 0; stall_err = 0; credit_err = 0; first_v = -1;
      prev_stall = 0; prev_data = '0;
   endtask

   always @(negedge CLK) begin
      busy_h[cyc] = BUSY;
      if (!RESET) begin
         // a read may only issue while fewer than 2 words are outstanding
         if (RE) begin
            ra_q.push_back(int'(RADDR));
            if (issued - xfers >= 2) credit_err++;
            issued++;
         end
         if (prev_stall && (!O_VALID || O_DATA !== prev_data)) stall_err++;
         if (O_VALID && first_v < 0) first_v = cyc;
         if (O_VALID && O_READY) begin
            got_q.push_back(O_DATA);
            xcyc_q.push_back(cyc);
            xfers++;
         end
         if (DONE) done_q.push_back(cyc);
         prev_stall = O_VALID && !O_READY;
         prev_data  = O_DATA;
      end
   end

   function automatic logic rdy(input int mode, input int i);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (i % 3 == 0);
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic drive_burst(input int base, input int len, input int mode,
                              input int budget, output int scyc, output bit tmo);
      @(posedge CLK); #1;
      clear_mon();
      START = 1'b1; BASE = 11'(base); LENGTH = 9'(len);
      O_READY = rdy(mode, 0); scyc = cyc;
      @(posedge CLK); #1;
      START = 1'b0;
      tmo = 1'b1;
      for (int i = 1; i <= budget; i++) begin
         O_READY = rdy(mode, i);
         @(negedge CLK);
         if (DONE) begin tmo = 1'b0; break; end
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
      O_READY = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      tests++;
      if ({RADDR, RE, O_VALID, O_DATA, BUSY, DONE} !== '0) begin
         fails++;
         $display("FAIL reset_values got raddr=%0h re=%b v=%b d=%0h busy=%b done=%b exp all 0",
                  RADDR, RE, O_VALID, O_DATA, BUSY, DONE);
      end
   endtask

   task automatic test_basic();
      int s; bit tmo;
      rom[0] = 16'h0001; rom[1] = 16'h00FF;
      drive_burst(0, 2, 0, 20, s, tmo);
      tests++; if (tmo) begin fails++; $display("FAIL basic_timeout got no DONE exp DONE"); end
      tests++;
      if (got_q.size() != 2) begin
         fails++; $display("FAIL basic_count got %0d exp 2", got_q.size());
      end else begin
         tests++; if (got_q[0] !== 16'h0001) begin fails++; $display("FAIL basic_w0 got %0h exp 1", got_q[0]); end
         tests++; if (got_q[1] !== 16'h00FF) begin fails++; $display("FAIL basic_w1 got %0h exp ff", got_q[1]); end
         tests++; if (xcyc_q[0] != s + 2) begin fails++; $display("FAIL basic_latency got %0d exp %0d", xcyc_q[0] - s, 2); end
         tests++; if (xcyc_q[1] != s + 3) begin fails++; $display("FAIL basic_rate got %0d exp %0d", xcyc_q[1] - s, 3); end
         tests++;
         if (done_q.size() != 1 || done_q[0] != xcyc_q[1]) begin
            fails++; $display("FAIL basic_done got n=%0d exp 1 at cycle %0d", done_q.size(), xcyc_q[1] - s);
         end
      end
      tests++; if (busy_h[s + 1] !== 1'b1) begin fails++; $display("FAIL basic_busy_on got %b exp 1", busy_h[s + 1]); end
      tests++; if (busy_h[s + 4] !== 1'b0) begin fails++; $display("FAIL basic_busy_off got %b exp 0", busy_h[s + 4]); end
   endtask

   task automatic test_wrap();
      int s; bit tmo;
      drive_burst(254, 4, 0, 30, s, tmo);
      tests++; if (tmo) begin fails++; $display("FAIL wrap_timeout got no DONE exp DONE"); end
      tests++;
      if (ra_q.size() != 4 || got_q.size() != 4) begin
         fails++; $display("FAIL wrap_count got reads=%0d words=%0d exp 4", ra_q.size(), got_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (ra_q[i] != (254 + i) % 256) begin
               fails++; $display("FAIL wrap_raddr[%0d] got %0d exp %0d", i, ra_q[i], (254 + i) % 256);
            end
            tests++;
            if (got_q[i] !== rom[(254 + i) % 256]) begin
               fails++; $display("FAIL wrap_word[%0d] got %0h exp %0h", i, got_q[i], rom[(254 + i) % 256]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int s; bit tmo; int b;
      b = 100;
      drive_burst(b, 8, 1, 80, s, tmo);
      tests++; if (tmo) begin fails++; $display("FAIL bp_timeout got no DONE exp DONE"); end
      tests++; if (ra_q.size() != 8) begin fails++; $display("FAIL bp_reads got %0d exp 8", ra_q.size()); end
      tests++;
      if (got_q.size() != 8) begin
         fails++; $display("FAIL bp_count got %0d exp 8", got_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            tests++;
            if (got_q[i] !== rom[b + i]) begin
               fails++; $display("FAIL bp_word[%0d] got %0h exp %0h", i, got_q[i], rom[b + i]);
            end
         end
      end
      tests++; if (stall_err != 0) begin fails++; $display("FAIL bp_stable got %0d unstable cycles exp 0", stall_err); end
      tests++; if (credit_err != 0) begin fails++; $display("FAIL bp_credit got %0d overissues exp 0", credit_err); end
   endtask

   task automatic test_zero_len();
      int s; bit tmo;
      drive_burst(17, 0, 0, 10, s, tmo);
      repeat (3) @(posedge CLK);
      #1;
      tests++; if (tmo) begin fails++; $display("FAIL zero_timeout got no DONE exp DONE"); end
      tests++; if (ra_q.size() != 0) begin fails++; $display("FAIL zero_re got %0d reads exp 0", ra_q.size()); end
      tests++; if (first_v != -1) begin fails++; $display("FAIL zero_valid got valid at %0d exp never", first_v - s); end
      tests++;
      if (done_q.size() != 1 || done_q[0] != s + 1) begin
         fails++; $display("FAIL zero_done got n=%0d exp 1 pulse at START+1", done_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int s; bit tmo; int b;
      @(posedge CLK); #1;
      clear_mon();
      b = 40;
      START = 1'b1; BASE = 11'(b); LENGTH = 9'd8; O_READY = 1'b0;
      @(posedge CLK); #1;
      START = 1'b0; RESET = 1'b1;   // read issued this cycle, word returns after reset
      @(posedge CLK); #1;
      RESET = 1'b0;
      clear_mon();
      @(negedge CLK);
      tests++;
      if ({RADDR, RE, O_VALID, O_DATA, BUSY, DONE} !== '0) begin
         fails++;
         $display("FAIL midreset_values got raddr=%0h re=%b v=%b d=%0h busy=%b done=%b exp all 0",
                  RADDR, RE, O_VALID, O_DATA, BUSY, DONE);
      end
      @(posedge CLK); #1;
      O_READY = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      tests++; if (first_v != -1 || got_q.size() != 0) begin fails++; $display("FAIL midreset_stale got %0d words exp 0", got_q.size()); end
      drive_burst(b, 5, 2, 60, s, tmo);
      tests++; if (tmo) begin fails++; $display("FAIL midreset_timeout got no DONE exp DONE"); end
      tests++;
      if (got_q.size() != 5) begin
         fails++; $display("FAIL midreset_count got %0d exp 5", got_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            tests++;
            if (got_q[i] !== rom[b + i]) begin
               fails++; $display("FAIL midreset_word[%0d] got %0h exp %0h", i, got_q[i], rom[b + i]);
            end
         end
      end
   endtask

   task automatic test_start_busy();
      bit tmo; int b;
      b = 200;
      @(posedge CLK); #1;
      clear_mon();
      START = 1'b1; BASE = 11'(b); LENGTH = 9'd6; O_READY = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      @(posedge CLK); #1;
      START = 1'b1; BASE = 11'd5; LENGTH = 9'd3; O_READY = 1'b0;
      @(posedge CLK); #1;
      START = 1'b0;
      tmo = 1'b1;
      for (int i = 0; i < 60; i++) begin
         O_READY = rdy(2, i);
         @(negedge CLK);
         if (DONE) begin tmo = 1'b0; break; end
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
      O_READY = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      O_READY = 1'b0;
      tests++; if (tmo) begin fails++; $display("FAIL busystart_timeout got no DONE exp DONE"); end
      tests++; if (ra_q.size() != 6) begin fails++; $display("FAIL busystart_reads got %0d exp 6", ra_q.size()); end
      tests++; if (done_q.size() != 1) begin fails++; $display("FAIL busystart_done got %0d pulses exp 1", done_q.size()); end
      tests++;
      if (got_q.size() != 6) begin
         fails++; $display("FAIL busystart_count got %0d exp 6", got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_q[i] !== rom[b + i]) begin
               fails++; $display("FAIL busystart_word[%0d] got %0h exp %0h", i, got_q[i], rom[b + i]);
            end
         end
      end
   endtask

   task automatic test_random();
      int s; bit tmo; int b; int len; int last;
      for (int n = 0; n < 16; n++) begin
         b   = int'($urandom_range(0, 255));
         len = (n == 0) ? 256 : int'($urandom_range(0, 24));
         drive_burst(b, len, 2, len * 8 + 20, s, tmo);
         tests++; if (tmo) begin fails++; $display("FAIL rand%0d_timeout got no DONE exp DONE", n); end
         tests++;
         if (got_q.size() != len || ra_q.size() != len) begin
            fails++; $display("FAIL rand%0d_count got words=%0d reads=%0d exp %0d", n, got_q.size(), ra_q.size(), len);
            continue;
         end
         for (int i = 0; i < len; i++) begin
            tests++;
            if (ra_q[i] != (b + i) % 256 || got_q[i] !== rom[(b + i) % 256]) begin
               fails++; $display("FAIL rand%0d_item[%0d] got addr=%0d word=%0h exp addr=%0d word=%0h",
                                 n, i, ra_q[i], got_q[i], (b + i) % 256, rom[(b + i) % 256]);
            end
         end
         last = (len == 0) ? s + 1 : xcyc_q[len - 1];
         tests++;
         if (done_q.size() != 1 || done_q[0] != last) begin
            fails++; $display("FAIL rand%0d_done got n=%0d exp 1 pulse at cycle offset %0d", n, done_q.size(), last - s);
         end
         tests++; if (stall_err != 0) begin fails++; $display("FAIL rand%0d_stable got %0d exp 0", n, stall_err); end
         tests++; if (credit_err != 0) begin fails++; $display("FAIL rand%0d_credit got %0d exp 0", n, credit_err); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      clear_mon();
      repeat (3) @(posedge CLK);
      test_reset();
      @(posedge CLK); #1;
      RESET = 1'b0;
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_reset_mid();
      test_start_busy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got no finish exp finish");
      $fatal(1, "timeout");
   end

endmodule
